// File: rtl/hdmi_data_island_decoder.sv
// HDMI data-island sink: de-serialises 32-cycle TERC4-decoded packets, checks BCH ECC and framing,
// and extracts ACR (CTS/N) and 16-bit L/R audio samples from accepted packets.
module hdmi_data_island_decoder #(
  parameter int DROP_BAD = 1,
  parameter int CNT_W    = 16
) (
  input  logic             i_pixclk,
  input  logic             i_rst_n,
  input  logic             i_data,
  input  logic [3:0]       i_d0,
  input  logic [3:0]       i_d1,
  input  logic [3:0]       i_d2,
  output logic             o_pkt_valid,
  output logic [23:0]      o_pkt_hdr,
  output logic [223:0]     o_pkt_sub,
  output logic [4:0]       o_ecc_ok,
  output logic             o_frame_err,
  output logic [19:0]      o_cts,
  output logic [19:0]      o_n,
  output logic             o_acr_valid,
  output logic [15:0]      o_audio_l,
  output logic [15:0]      o_audio_r,
  output logic             o_audio_valid,
  output logic [CNT_W-1:0] o_err_count
);

  localparam logic [7:0] HB0_ACR   = 8'h01;
  localparam logic [7:0] HB0_AUDIO = 8'h02;

  function automatic logic [7:0] f_step(input logic [7:0] code, input logic b);
    f_step = {code[6:0], 1'b0} ^ ((code[7] ^ b) ? 8'hC1 : 8'h00);
  endfunction

  function automatic logic [7:0] f_rev(input logic [7:0] v);
    for (int unsigned j = 0; j < 8; j++) f_rev[j] = v[7-j];
  endfunction

  function automatic logic [1:0] f_low(input logic [3:0] m);
    f_low = m[0] ? 2'd0 : m[1] ? 2'd1 : m[2] ? 2'd2 : 2'd3;
  endfunction

  logic             r_data_q;
  logic             r_active;
  logic             r_first;
  logic [4:0]       r_cnt;
  logic [23:0]      r_hdr;
  logic [7:0]       r_hpar;
  logic [7:0]       r_hcode;
  logic [3:0][55:0] r_sub;
  logic [3:0][7:0]  r_spar;
  logic [3:0][7:0]  r_scode;
  logic             r_ferr;
  logic [3:0]       r_amask;
  logic [3:0][55:0] r_psub;

  logic             w_rise;
  logic             w_act;
  logic             w_done;
  logic [4:0]       w_c;
  logic [23:0]      w_hdr_nxt;
  logic [7:0]       w_hpar_nxt;
  logic [7:0]       w_hcode_nxt;
  logic [7:0]       w_hbase;
  logic [3:0][55:0] w_sub_nxt;
  logic [3:0][7:0]  w_spar_nxt;
  logic [3:0][7:0]  w_scode_nxt;
  logic [7:0]       w_sbase;
  logic             w_fmis;
  logic             w_ferr_nxt;
  logic [4:0]       w_ecc;
  logic             w_bad;
  logic             w_accept;
  logic [3:0]       w_amask;
  logic [1:0]       w_k0;
  logic [1:0]       w_kc;
  logic             w_unused_sync;

  // Sync bits are recovered elsewhere; kept only to document that they are deliberately dropped.
  assign w_unused_sync = &i_d0[1:0];

  assign w_rise = i_data & ~r_data_q;
  assign w_act  = i_data & (r_active | w_rise);
  assign w_c    = w_rise ? 5'd0 : r_cnt;
  assign w_done = w_act && (w_c == 5'd31);

  always_comb begin
    w_hbase     = (w_c == 5'd0) ? 8'h00 : r_hcode;
    w_hdr_nxt   = r_hdr;
    w_hpar_nxt  = r_hpar;
    w_hcode_nxt = w_hbase;
    if (w_c < 5'd24) begin
      w_hdr_nxt   = {i_d0[2], r_hdr[23:1]};
      w_hcode_nxt = f_step(w_hbase, i_d0[2]);
    end else begin
      w_hpar_nxt  = {i_d0[2], r_hpar[7:1]};
    end
    w_ecc[0] = (w_hpar_nxt == f_rev(w_hcode_nxt));

    w_sub_nxt   = r_sub;
    w_spar_nxt  = r_spar;
    w_scode_nxt = r_scode;
    w_sbase     = 8'h00;
    for (int unsigned k = 0; k < 4; k++) begin
      w_sbase = (w_c == 5'd0) ? 8'h00 : r_scode[k];
      w_scode_nxt[k] = w_sbase;
      if (w_c < 5'd28) begin
        w_sub_nxt[k]   = {i_d2[k], i_d1[k], r_sub[k][55:2]};
        w_scode_nxt[k] = f_step(f_step(w_sbase, i_d1[k]), i_d2[k]);
      end else begin
        w_spar_nxt[k]  = {i_d2[k], i_d1[k], r_spar[k][7:2]};
      end
      w_ecc[k+1] = (w_spar_nxt[k] == f_rev(w_scode_nxt[k]));
    end

    // Framing bit is low only at the very first cycle of an island.
    w_fmis     = i_d0[3] != !(r_first && (w_c == 5'd0));
    w_ferr_nxt = (w_c == 5'd0) ? w_fmis : (r_ferr | w_fmis);
    w_bad      = (w_ecc != 5'h1F) || w_ferr_nxt;
    w_accept   = !w_bad || (DROP_BAD == 0);
    w_amask    = w_hdr_nxt[11:8];
    w_k0       = f_low(w_amask);
    w_kc       = f_low(r_amask);
  end

  always_ff @(posedge i_pixclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data_q      <= 1'b1;
      r_active      <= 1'b0;
      r_first       <= 1'b1;
      r_cnt         <= '0;
      r_hdr         <= '0;
      r_hpar        <= '0;
      r_hcode       <= '0;
      r_sub         <= '0;
      r_spar        <= '0;
      r_scode       <= '0;
      r_ferr        <= 1'b0;
      r_amask       <= '0;
      r_psub        <= '0;
      o_pkt_valid   <= 1'b0;
      o_pkt_hdr     <= '0;
      o_ecc_ok      <= '0;
      o_frame_err   <= 1'b0;
      o_cts         <= '0;
      o_n           <= '0;
      o_acr_valid   <= 1'b0;
      o_audio_l     <= '0;
      o_audio_r     <= '0;
      o_audio_valid <= 1'b0;
      o_err_count   <= '0;
    end else begin
      r_data_q      <= i_data;
      o_pkt_valid   <= 1'b0;
      o_acr_valid   <= 1'b0;
      o_audio_valid <= 1'b0;

      if (r_amask != 4'd0) begin
        o_audio_valid <= 1'b1;
        o_audio_l     <= r_psub[w_kc][23:8];
        o_audio_r     <= r_psub[w_kc][47:32];
        r_amask       <= r_amask & (r_amask - 4'd1);
      end

      if (w_act) begin
        r_active <= 1'b1;
        r_cnt    <= w_c + 5'd1;
        r_hdr    <= w_hdr_nxt;
        r_hpar   <= w_hpar_nxt;
        r_hcode  <= w_hcode_nxt;
        r_sub    <= w_sub_nxt;
        r_spar   <= w_spar_nxt;
        r_scode  <= w_scode_nxt;
        r_ferr   <= w_ferr_nxt;
        if (w_done) begin
          r_first     <= 1'b0;
          o_ecc_ok    <= w_ecc;
          o_frame_err <= w_ferr_nxt;
          if (w_bad && (o_err_count != '1)) o_err_count <= o_err_count + CNT_W'(1);
          if (w_accept) begin
            o_pkt_valid <= 1'b1;
            o_pkt_hdr   <= w_hdr_nxt;
            r_psub      <= w_sub_nxt;
            r_amask     <= '0;
            if (w_hdr_nxt[7:0] == HB0_ACR) begin
              o_acr_valid <= 1'b1;
              o_cts       <= {w_sub_nxt[0][11:8], w_sub_nxt[0][23:16], w_sub_nxt[0][31:24]};
              o_n         <= {w_sub_nxt[0][35:32], w_sub_nxt[0][47:40], w_sub_nxt[0][55:48]};
            end
            // First sample leaves with the packet strobe; the rest drain from r_amask.
            if ((w_hdr_nxt[7:0] == HB0_AUDIO) && (w_amask != 4'd0)) begin
              o_audio_valid <= 1'b1;
              o_audio_l     <= w_sub_nxt[w_k0][23:8];
              o_audio_r     <= w_sub_nxt[w_k0][47:32];
              r_amask       <= w_amask & (w_amask - 4'd1);
            end
          end
        end
      end else if (!i_data) begin
        r_active <= 1'b0;
        r_cnt    <= '0;
        r_first  <= 1'b1;
        if (r_active && (r_cnt != 5'd0)) begin
          r_hcode <= '0;
          r_scode <= '0;
          if (o_err_count != '1) o_err_count <= o_err_count + CNT_W'(1);
        end
      end
    end
  end

  assign o_pkt_sub = r_psub;

endmodule

// File: tb/tb_hdmi_data_island_decoder.sv
// Self-checking bench for hdmi_data_island_decoder: a packet encoder drives islands, a scoreboard
// checks every packet/ACR/audio strobe, and scenario tasks check drops, errors and reset.
module tb_hdmi_data_island_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        i_data;
  logic [3:0]  d0, d1, d2;

  logic        o_pkt_valid, o_frame_err, o_acr_valid, o_audio_valid;
  logic [23:0] o_pkt_hdr;
  logic [223:0] o_pkt_sub;
  logic [4:0]  o_ecc_ok;
  logic [19:0] o_cts, o_n;
  logic [15:0] o_audio_l, o_audio_r;
  logic [15:0] o_err_count;

  logic        s_pkt_valid, s_frame_err, s_acr_valid, s_audio_valid;
  logic [23:0] s_pkt_hdr;
  logic [223:0] s_pkt_sub;
  logic [4:0]  s_ecc_ok;
  logic [19:0] s_cts, s_n;
  logic [15:0] s_audio_l, s_audio_r;
  logic [3:0]  s_err_count;

  hdmi_data_island_decoder #(.DROP_BAD(1), .CNT_W(16)) dut (
    .i_pixclk(clk), .i_rst_n(rst_n), .i_data(i_data), .i_d0(d0), .i_d1(d1), .i_d2(d2),
    .o_pkt_valid(o_pkt_valid), .o_pkt_hdr(o_pkt_hdr), .o_pkt_sub(o_pkt_sub), .o_ecc_ok(o_ecc_ok),
    .o_frame_err(o_frame_err), .o_cts(o_cts), .o_n(o_n), .o_acr_valid(o_acr_valid),
    .o_audio_l(o_audio_l), .o_audio_r(o_audio_r), .o_audio_valid(o_audio_valid),
    .o_err_count(o_err_count));

  hdmi_data_island_decoder #(.DROP_BAD(1), .CNT_W(4)) dut_sat (
    .i_pixclk(clk), .i_rst_n(rst_n), .i_data(i_data), .i_d0(d0), .i_d1(d1), .i_d2(d2),
    .o_pkt_valid(s_pkt_valid), .o_pkt_hdr(s_pkt_hdr), .o_pkt_sub(s_pkt_sub), .o_ecc_ok(s_ecc_ok),
    .o_frame_err(s_frame_err), .o_cts(s_cts), .o_n(s_n), .o_acr_valid(s_acr_valid),
    .o_audio_l(s_audio_l), .o_audio_r(s_audio_r), .o_audio_valid(s_audio_valid),
    .o_err_count(s_err_count));

  typedef struct {
    logic [23:0]  hdr;
    logic [223:0] sub;
    logic [4:0]   ecc;
    logic         ferr;
  } pkt_t;

  pkt_t        pq[$];
  logic [39:0] acrq[$];
  logic [31:0] audq[$];
  pkt_t        me;
  logic [39:0] ma;
  logic [31:0] mu;

  int checks = 0;
  int failures = 0;
  int exp_err = 0;

  logic [223:0] acr_sub;
  logic [223:0] aud_sub;

  // Reference BCH parity: P[j] = code[7-j] after feeding n data bits LSB first.
  function automatic logic [7:0] bch(input logic [55:0] d, input int n);
    logic [7:0] code;
    logic [7:0] p;
    code = 8'h00;
    for (int i = 0; i < n; i++)
      code = {code[6:0], 1'b0} ^ ((code[7] ^ d[i]) ? 8'hC1 : 8'h00);
    for (int j = 0; j < 8; j++) p[j] = code[7-j];
    return p;
  endfunction

  task automatic send_packet(input logic [23:0] hdr, input logic [223:0] sub, input bit first,
                             input int ncyc, input int hp_flip, input int sflip, input bit fflip);
    logic [7:0]       hp;
    logic [3:0][7:0]  sp;
    logic [3:0][55:0] s;
    logic [223:0]     sf;
    s  = sub;
    hp = bch({32'h0, hdr}, 24);
    for (int k = 0; k < 4; k++) sp[k] = bch(s[k], 56);
    if (hp_flip >= 0) hp[hp_flip] = ~hp[hp_flip];
    sf = sub;
    if (sflip >= 0) sf[sflip] = ~sf[sflip];
    s = sf;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      i_data  = 1'b1;
      d0[1:0] = 2'($urandom_range(3, 0));
      d0[2]   = (c < 24) ? hdr[c] : hp[c-24];
      d0[3]   = (first && c == 0) ? fflip : 1'b1;
      for (int k = 0; k < 4; k++) begin
        d1[k] = (c < 28) ? s[k][2*c]   : sp[k][2*(c-28)];
        d2[k] = (c < 28) ? s[k][2*c+1] : sp[k][2*(c-28)+1];
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      i_data = 1'b0; d0 = 4'h0; d1 = 4'h0; d2 = 4'h0;
    end
  endtask

  // Scoreboard: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (o_pkt_valid) begin
      checks++;
      if (pq.size() == 0) begin
        failures++;
        $display("FAIL pkt_unexpected got hdr=%h ecc=%h", o_pkt_hdr, o_ecc_ok);
      end else begin
        me = pq.pop_front();
        if ({o_pkt_hdr, o_pkt_sub, o_ecc_ok, o_frame_err} !== {me.hdr, me.sub, me.ecc, me.ferr}) begin
          failures++;
          $display("FAIL pkt_content got hdr=%h ecc=%h ferr=%b sub=%h exp hdr=%h ecc=%h ferr=%b sub=%h",
                   o_pkt_hdr, o_ecc_ok, o_frame_err, o_pkt_sub, me.hdr, me.ecc, me.ferr, me.sub);
        end
      end
    end
    if (o_acr_valid) begin
      checks++;
      if (acrq.size() == 0) begin
        failures++;
        $display("FAIL acr_unexpected got cts=%0d n=%0d", o_cts, o_n);
      end else begin
        ma = acrq.pop_front();
        if ({o_cts, o_n} !== ma) begin
          failures++;
          $display("FAIL acr_value got cts=%0d n=%0d exp cts=%0d n=%0d", o_cts, o_n, ma[39:20], ma[19:0]);
        end
      end
    end
    if (o_audio_valid) begin
      checks++;
      if (audq.size() == 0) begin
        failures++;
        $display("FAIL audio_unexpected got l=%h r=%h", o_audio_l, o_audio_r);
      end else begin
        mu = audq.pop_front();
        if ({o_audio_l, o_audio_r} !== mu) begin
          failures++;
          $display("FAIL audio_value got l=%h r=%h exp l=%h r=%h", o_audio_l, o_audio_r, mu[31:16], mu[15:0]);
        end
      end
    end
  end

  task automatic check_queues_empty(input string name);
    checks++;
    if (pq.size() != 0 || acrq.size() != 0 || audq.size() != 0) begin
      failures++;
      $display("FAIL %s_pending got pkt=%0d acr=%0d aud=%0d exp 0 0 0", name, pq.size(), acrq.size(), audq.size());
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; i_data = 1'b0; d0 = 4'h0; d1 = 4'h0; d2 = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({o_pkt_valid, o_pkt_hdr, o_pkt_sub, o_ecc_ok, o_frame_err, o_cts, o_n, o_acr_valid,
         o_audio_l, o_audio_r, o_audio_valid, o_err_count, s_err_count} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got hdr=%h ecc=%h cts=%h n=%h err=%h exp all 0",
               o_pkt_hdr, o_ecc_ok, o_cts, o_n, o_err_count);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_acr;
    pq.push_back('{24'h000001, acr_sub, 5'h1F, 1'b0});
    acrq.push_back({20'd25200, 20'd6144});
    send_packet(24'h000001, acr_sub, 1'b1, 32, -1, -1, 1'b0);
    idle(1);
    @(negedge clk);
    checks++;
    if (o_pkt_valid !== 1'b1 || o_acr_valid !== 1'b1) begin
      failures++;
      $display("FAIL acr_latency got valid=%b acr_valid=%b exp 1 1", o_pkt_valid, o_acr_valid);
    end
    checks++;
    if (o_cts !== 20'd25200 || o_n !== 20'd6144 || o_ecc_ok !== 5'h1F) begin
      failures++;
      $display("FAIL acr_fields got cts=%0d n=%0d ecc=%h exp 25200 6144 1f", o_cts, o_n, o_ecc_ok);
    end
    @(negedge clk);
    checks++;
    if (o_acr_valid !== 1'b0 || o_pkt_valid !== 1'b0 || o_cts !== 20'd25200) begin
      failures++;
      $display("FAIL acr_strobe_width got acr_valid=%b valid=%b cts=%0d exp 0 0 25200", o_acr_valid, o_pkt_valid, o_cts);
    end
    idle(3);
    check_queues_empty("acr");
  endtask

  task automatic test_back_to_back;
    pq.push_back('{24'h000001, acr_sub, 5'h1F, 1'b0});
    acrq.push_back({20'd25200, 20'd6144});
    pq.push_back('{24'h000302, aud_sub, 5'h1F, 1'b0});
    audq.push_back({16'h1234, 16'hABCD});
    audq.push_back({16'h8000, 16'h7FFF});
    send_packet(24'h000001, acr_sub, 1'b1, 32, -1, -1, 1'b0);
    send_packet(24'h000302, aud_sub, 1'b0, 32, -1, -1, 1'b0);
    idle(8);
    check_queues_empty("back_to_back");
    checks++;
    if (o_frame_err !== 1'b0 || o_err_count !== 16'(exp_err)) begin
      failures++;
      $display("FAIL b2b_errors got ferr=%b err=%0d exp 0 %0d", o_frame_err, o_err_count, exp_err);
    end
  endtask

  task automatic test_bad_packet(input string name, input int hp_flip, input int sflip, input bit fflip,
                                 input logic [4:0] exp_ecc, input logic exp_ferr);
    send_packet(24'h000001, acr_sub, 1'b1, 32, hp_flip, sflip, fflip);
    exp_err++;
    idle(1);
    @(negedge clk);
    checks++;
    if (o_pkt_valid !== 1'b0 || o_ecc_ok !== exp_ecc || o_frame_err !== exp_ferr) begin
      failures++;
      $display("FAIL %s_status got valid=%b ecc=%h ferr=%b exp 0 %h %b", name, o_pkt_valid, o_ecc_ok, o_frame_err, exp_ecc, exp_ferr);
    end
    checks++;
    if (o_err_count !== 16'(exp_err)) begin
      failures++;
      $display("FAIL %s_errcount got %0d exp %0d", name, o_err_count, exp_err);
    end
    idle(3);
    check_queues_empty(name);
  endtask

  task automatic test_truncation;
    send_packet(24'h000001, acr_sub, 1'b1, 17, -1, -1, 1'b0);
    exp_err++;
    idle(2);
    @(negedge clk);
    checks++;
    if (o_err_count !== 16'(exp_err)) begin
      failures++;
      $display("FAIL trunc_errcount got %0d exp %0d", o_err_count, exp_err);
    end
    // A clean packet right after must still decode with fresh ECC state.
    pq.push_back('{24'h000001, acr_sub, 5'h1F, 1'b0});
    acrq.push_back({20'd25200, 20'd6144});
    send_packet(24'h000001, acr_sub, 1'b1, 32, -1, -1, 1'b0);
    idle(4);
    check_queues_empty("trunc");
  endtask

  task automatic test_reset_mid;
    send_packet(24'h000001, acr_sub, 1'b1, 10, -1, -1, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({o_pkt_valid, o_pkt_hdr, o_pkt_sub, o_ecc_ok, o_frame_err, o_cts, o_n, o_acr_valid,
         o_audio_l, o_audio_r, o_audio_valid, o_err_count, s_err_count} !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs got hdr=%h ecc=%h cts=%0d err=%0d exp all 0", o_pkt_hdr, o_ecc_ok, o_cts, o_err_count);
    end
    exp_err = 0;
    @(posedge clk); #2 rst_n = 1'b1;
    send_packet(24'h000001, acr_sub, 1'b0, 32, -1, -1, 1'b0);
    send_packet(24'h000001, acr_sub, 1'b0, 32, -1, -1, 1'b0);
    idle(3);
    @(negedge clk);
    checks++;
    if (o_err_count !== 16'd0 || o_cts !== 20'd0) begin
      failures++;
      $display("FAIL reset_mid_quiet got err=%0d cts=%0d exp 0 0", o_err_count, o_cts);
    end
    check_queues_empty("reset_mid");
  endtask

  task automatic test_saturation;
    for (int i = 1; i <= 20; i++) begin
      send_packet(24'h000001, acr_sub, 1'b1, 3, -1, -1, 1'b0);
      exp_err++;
      idle(2);
      @(negedge clk);
      if (i == 14 || i == 15 || i == 20) begin
        checks++;
        if (s_err_count !== 4'((i > 15) ? 15 : i) || o_err_count !== 16'(exp_err)) begin
          failures++;
          $display("FAIL saturation_%0d got sat=%h wide=%0d exp sat=%h wide=%0d",
                   i, s_err_count, o_err_count, 4'((i > 15) ? 15 : i), exp_err);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    acr_sub[55:0]    = {8'h00, 8'h18, 8'h00, 8'h70, 8'h62, 8'h00, 8'h00};
    acr_sub[111:56]  = acr_sub[55:0];
    acr_sub[167:112] = acr_sub[55:0];
    acr_sub[223:168] = acr_sub[55:0];
    aud_sub[55:0]    = {8'h00, 16'hABCD, 8'h00, 16'h1234, 8'h00};
    aud_sub[111:56]  = {8'h00, 16'h7FFF, 8'h00, 16'h8000, 8'h00};
    aud_sub[167:112] = {24'($urandom), $urandom};
    aud_sub[223:168] = {24'($urandom), $urandom};

    test_reset();
    test_acr();
    test_back_to_back();
    test_bad_packet("ecc_hdr", 3, -1, 1'b0, 5'h1E, 1'b0);
    test_bad_packet("ecc_sub2", -1, 2*56 + 10, 1'b0, 5'h17, 1'b0);
    test_bad_packet("framing", -1, -1, 1'b1, 5'h1F, 1'b1);
    test_truncation();
    test_reset_mid();
    test_saturation();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
